// File: rtl/matrix_mgr_arbiter.sv
// matrix_mgr_arbiter
//   Shares the matrix manager (alloc/commit handshake) and the BRAM write port
//   between NUM_REQ mode controllers. A requester owns the resource from alloc
//   through commit; ownership rotates round-robin. A stalled owner is aborted
//   after TIMEOUT_CYC cycles without progress so the manager cannot lock up.
//
// Ports
//   clk, rst                 clock (posedge) / asynchronous active-high reset
//   req_alloc[i]             level request for ownership
//   req_commit[i] + fields   commit pulse with slot/m/n/addr, packed per requester
//   req_wr_en/addr/data[i]   per-requester BRAM write
//   grant                    one-hot current owner, 0 when free
//   alloc_valid/slot/addr    1-cycle pulse to owner with allocated slot/address
//   abort                    1-cycle pulse to owner on timeout
//   wr_drop                  1-cycle pulse per discarded (non-owner) write
//   mgr_alloc_*              alloc handshake with the matrix manager
//   mgr_commit_*             registered commit forwarded to the manager
//   mem_wr_*                 registered owner write to the BRAM port
module matrix_mgr_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 10,
  parameter int ELEMENT_WIDTH = 16,
  parameter int TIMEOUT_CYC   = 1000000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_alloc,
  input  logic [NUM_REQ-1:0]               req_commit,
  input  logic [4*NUM_REQ-1:0]             req_commit_slot,
  input  logic [5*NUM_REQ-1:0]             req_commit_m,
  input  logic [5*NUM_REQ-1:0]             req_commit_n,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_commit_addr,
  input  logic [NUM_REQ-1:0]               req_wr_en,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_wr_addr,
  input  logic [ELEMENT_WIDTH*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               alloc_valid,
  output logic [3:0]                       alloc_slot,
  output logic [ADDR_WIDTH-1:0]            alloc_addr,
  output logic [NUM_REQ-1:0]               abort,
  output logic [NUM_REQ-1:0]               wr_drop,
  output logic                             mgr_alloc_req,
  input  logic [3:0]                       mgr_alloc_slot,
  input  logic [ADDR_WIDTH-1:0]            mgr_alloc_addr,
  input  logic                             mgr_alloc_valid,
  output logic                             mgr_commit_req,
  output logic [3:0]                       mgr_commit_slot,
  output logic [4:0]                       mgr_commit_m,
  output logic [4:0]                       mgr_commit_n,
  output logic [ADDR_WIDTH-1:0]            mgr_commit_addr,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0]         mem_wr_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ALLOC_WAIT, S_OWNED} state_t;

  state_t                   state_q;
  logic [NUM_REQ-1:0]       grant_q, alloc_valid_q, abort_q, wr_drop_q;
  logic [IDX_W-1:0]         owner_q, last_grant_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [3:0]               alloc_slot_q, commit_slot_q;
  logic [ADDR_WIDTH-1:0]    alloc_addr_q, commit_addr_q, wr_addr_q;
  logic [4:0]               commit_m_q, commit_n_q;
  logic                     mgr_alloc_req_q, commit_req_q, wr_en_q;
  logic [ELEMENT_WIDTH-1:0] wr_data_q;

  logic                     win_found_d;
  logic [IDX_W-1:0]         win_idx_d, scan_idx;
  logic                     own_wr_en, own_commit;
  logic [ADDR_WIDTH-1:0]    own_wr_addr, own_commit_addr;
  logic [ELEMENT_WIDTH-1:0] own_wr_data;
  logic [3:0]               own_commit_slot;
  logic [4:0]               own_commit_m, own_commit_n;
  logic [NUM_REQ-1:0]       wr_accept;
  logic                     timeout_hit;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    idx2oh      = '0;
    idx2oh[idx] = 1'b1;
  endfunction

  // Round-robin: scan starting one past the last owner, wrapping at NUM_REQ.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    scan_idx    = last_grant_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (scan_idx == IDX_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!win_found_d && req_alloc[scan_idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = scan_idx;
      end
    end
  end

  // Select the current owner's write and commit fields.
  always_comb begin
    own_wr_en       = 1'b0;
    own_commit      = 1'b0;
    own_wr_addr     = '0;
    own_wr_data     = '0;
    own_commit_slot = '0;
    own_commit_m    = '0;
    own_commit_n    = '0;
    own_commit_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_wr_en       = req_wr_en[i];
        own_commit      = req_commit[i];
        own_wr_addr     = req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_wr_data     = req_wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        own_commit_slot = req_commit_slot[i*4 +: 4];
        own_commit_m    = req_commit_m[i*5 +: 5];
        own_commit_n    = req_commit_n[i*5 +: 5];
        own_commit_addr = req_commit_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only the owner in OWNED reaches the BRAM; every other strobe is dropped,
  // including the owner's own writes before its allocation has arrived.
  assign wr_accept   = (state_q == S_OWNED) ? grant_q : '0;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      owner_q         <= '0;
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q           <= '0;
      alloc_valid_q   <= '0;
      alloc_slot_q    <= '0;
      alloc_addr_q    <= '0;
      abort_q         <= '0;
      wr_drop_q       <= '0;
      mgr_alloc_req_q <= 1'b0;
      commit_req_q    <= 1'b0;
      commit_slot_q   <= '0;
      commit_m_q      <= '0;
      commit_n_q      <= '0;
      commit_addr_q   <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      alloc_valid_q <= '0;
      abort_q       <= '0;
      commit_req_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_drop_q     <= req_wr_en & ~wr_accept;
      if (state_q == S_OWNED && own_wr_en) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= own_wr_addr;
        wr_data_q <= own_wr_data;
      end
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            grant_q         <= idx2oh(win_idx_d);
            owner_q         <= win_idx_d;
            mgr_alloc_req_q <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_ALLOC_WAIT;
          end
        end
        S_ALLOC_WAIT: begin
          if (mgr_alloc_valid) begin
            alloc_slot_q    <= mgr_alloc_slot;
            alloc_addr_q    <= mgr_alloc_addr;
            alloc_valid_q   <= grant_q;
            mgr_alloc_req_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= S_OWNED;
          end else if (timeout_hit) begin
            abort_q         <= grant_q;
            grant_q         <= '0;
            mgr_alloc_req_q <= 1'b0;
            last_grant_q    <= owner_q;
            state_q         <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OWNED: begin
          // Commit wins over timeout; a write in the same cycle was forwarded above.
          if (own_commit) begin
            commit_req_q  <= 1'b1;
            commit_slot_q <= own_commit_slot;
            commit_m_q    <= own_commit_m;
            commit_n_q    <= own_commit_n;
            commit_addr_q <= own_commit_addr;
            last_grant_q  <= owner_q;
            grant_q       <= '0;
            state_q       <= S_IDLE;
          end else if (own_wr_en) begin
            cnt_q <= '0;
          end else if (timeout_hit) begin
            abort_q      <= grant_q;
            grant_q      <= '0;
            last_grant_q <= owner_q;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant           = grant_q;
  assign alloc_valid     = alloc_valid_q;
  assign alloc_slot      = alloc_slot_q;
  assign alloc_addr      = alloc_addr_q;
  assign abort           = abort_q;
  assign wr_drop         = wr_drop_q;
  assign mgr_alloc_req   = mgr_alloc_req_q;
  assign mgr_commit_req  = commit_req_q;
  assign mgr_commit_slot = commit_slot_q;
  assign mgr_commit_m    = commit_m_q;
  assign mgr_commit_n    = commit_n_q;
  assign mgr_commit_addr = commit_addr_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = wr_addr_q;
  assign mem_wr_data     = wr_data_q;

endmodule
